// File: rtl/dense_layer_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_parameters (package)
//  Description : Shared constants, FSM state type and the output saturation
//                helper for the time-multiplexed dense layer.
//  Contents    : DENSE_IN_SIZE / DENSE_OUT_SIZE  per-layer default sizes
//                state_t                         layer FSM states
//                saturate()                      clamp to a signed width
//  Revision    : 1.0  initial release
// ============================================================================
package nn_parameters;

    localparam int DENSE_IN_SIZE  = 16;
    localparam int DENSE_OUT_SIZE = 8;

    // Widest value the saturation helper can take; accumulator widths of the
    // supported layer shapes stay well below this.
    localparam int SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp a signed value to the range of an out_w-bit signed number. The
    // caller truncates the returned value to out_w bits.
    function automatic logic signed [SAT_MAX_W-1:0] saturate(
        input logic signed [SAT_MAX_W-1:0] value,
        input int                          out_w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (value > hi) begin
            saturate = hi;
        end else if (value < lo) begin
            saturate = lo;
        end else begin
            saturate = value;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/dense_layer_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : dense_layer_seq_if
//  Description : Bundle of the dense layer's stream handshakes and its
//                weight / bias memory read ports.
//  Modports    : slave  - the layer itself
//                master - the surrounding system (producer, consumer, memories)
//  Signals     : in_valid/in_ready/in_vector     input vector stream
//                out_valid/out_ready/out_vector  result vector stream
//                w_rd_addr/w_rd_data             weight memory (1-cycle read)
//                b_rd_addr/b_rd_data             bias memory (1-cycle read)
//  Revision    : 1.0  initial release
// ============================================================================
interface dense_layer_seq_if #(
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 8,
    parameter int IN_W     = 8,
    parameter int W_W      = 8,
    parameter int B_W      = 16,
    parameter int OUT_W    = 24
);
    localparam int WA_W = $clog2(IN_SIZE * OUT_SIZE);
    localparam int BA_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    logic                            in_valid;
    logic                            in_ready;
    logic [IN_SIZE-1:0][IN_W-1:0]    in_vector;
    logic [WA_W-1:0]                 w_rd_addr;
    logic signed [W_W-1:0]           w_rd_data;
    logic [BA_W-1:0]                 b_rd_addr;
    logic signed [B_W-1:0]           b_rd_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [OUT_SIZE-1:0][OUT_W-1:0]  out_vector;

    modport slave (
        input  in_valid, in_vector, w_rd_data, b_rd_data, out_ready,
        output in_ready, w_rd_addr, b_rd_addr, out_valid, out_vector
    );

    modport master (
        output in_valid, in_vector, w_rd_data, b_rd_data, out_ready,
        input  in_ready, w_rd_addr, b_rd_addr, out_valid, out_vector
    );

endinterface
`default_nettype wire

// File: rtl/dense_layer_seq_mac.sv
`default_nettype none
// ============================================================================
//  Module      : dense_mac
//  Description : Shared multiply-accumulate datapath of the dense layer plus
//                the per-neuron result path (bias, shift, ReLU, saturation).
//  Ports       : clk, rst        clock, asynchronous active-high reset
//                clr             clear accumulator
//                en              accumulate x*w
//                last            final term of a neuron; result is valid
//                x, w, b         input element, weight, bias
//                result          finished neuron value (valid while last)
//                result_valid    write strobe for result
//  Revision    : 1.0  initial release
// ============================================================================
module dense_mac
    import nn_parameters::*;
#(
    parameter int IN_SIZE    = 16,
    parameter int IN_W       = 8,
    parameter int W_W        = 8,
    parameter int B_W        = 16,
    parameter int OUT_W      = 24,
    parameter int FRAC_SHIFT = 0,
    parameter int RELU       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    last,
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [W_W-1:0]   w,
    input  logic signed [B_W-1:0]   b,
    output logic signed [OUT_W-1:0] result,
    output logic                    result_valid
);
    localparam int c_prod_w = IN_W + W_W;
    localparam int c_sum_w  = c_prod_w + $clog2(IN_SIZE);
    // One guard bit above the larger of the summed products and the bias so
    // that the final bias add cannot overflow.
    localparam int c_acc_w  = ((c_sum_w > B_W) ? c_sum_w : B_W) + 1;

    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_acc_w-1:0]  w_prod_ext;
    logic signed [c_acc_w-1:0]  w_bias_ext;
    logic signed [c_acc_w-1:0]  w_sum;
    logic signed [c_acc_w-1:0]  w_shift;
    logic signed [c_acc_w-1:0]  w_act;
    logic signed [c_acc_w-1:0]  r_acc;

    assign w_prod     = c_prod_w'(x) * c_prod_w'(w);
    assign w_prod_ext = c_acc_w'(w_prod);
    assign w_bias_ext = c_acc_w'(b);

    // The last product of a neuron is folded in combinationally together
    // with the bias, so the accumulator only ever holds IN_SIZE-1 terms.
    assign w_sum   = r_acc + w_prod_ext + w_bias_ext;
    assign w_shift = w_sum >>> FRAC_SHIFT;
    assign w_act   = ((RELU != 0) && w_shift[c_acc_w-1]) ? '0 : w_shift;

    assign result       = OUT_W'(saturate(64'(w_act), OUT_W));
    assign result_valid = last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dense_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dense_layer_seq
//  Description : Time-multiplexed fully-connected layer. A captured input
//                vector is multiplied against OUT_SIZE weight rows, one
//                neuron at a time, through a single shared MAC.
//  Ports       : clk, rst   clock, asynchronous active-high reset
//                bus        dense_layer_seq_if.slave (vector streams and
//                           weight/bias memory read ports)
//  Timing      : each neuron takes IN_SIZE+1 cycles; out_valid rises
//                OUT_SIZE*(IN_SIZE+1)+1 cycles after the input handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module dense_layer_seq
    import nn_parameters::*;
#(
    parameter int IN_SIZE    = DENSE_IN_SIZE,
    parameter int OUT_SIZE   = DENSE_OUT_SIZE,
    parameter int IN_W       = 8,
    parameter int W_W        = 8,
    parameter int B_W        = 16,
    parameter int OUT_W      = 24,
    parameter int FRAC_SHIFT = 0,
    parameter int RELU       = 1
) (
    input  logic             clk,
    input  logic             rst,
    dense_layer_seq_if.slave bus
);
    localparam int c_k_w  = $clog2(IN_SIZE + 1);
    localparam int c_x_w  = $clog2(IN_SIZE);
    localparam int c_o_w  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int c_wa_w = $clog2(IN_SIZE * OUT_SIZE);

    state_t                         r_state;
    state_t                         w_state_next;
    logic                           r_alive;
    logic [c_k_w-1:0]               r_k;
    logic [c_o_w-1:0]               r_o;
    logic [c_wa_w-1:0]              r_waddr;
    logic [IN_SIZE-1:0][IN_W-1:0]   r_x;
    logic [OUT_SIZE-1:0][OUT_W-1:0] r_out;

    logic                           w_k_last;
    logic                           w_o_last;
    logic                           w_in_fire;
    logic                           w_out_fire;
    logic                           w_clr;
    logic                           w_en;
    logic                           w_last;
    logic [c_x_w-1:0]               w_xsel;
    logic signed [OUT_W-1:0]        w_result;
    logic                           w_result_valid;

    assign w_k_last   = (r_k == c_k_w'(IN_SIZE));
    assign w_o_last   = (r_o == c_o_w'(OUT_SIZE - 1));
    assign w_in_fire  = bus.in_valid && bus.in_ready;
    assign w_out_fire = bus.out_valid && bus.out_ready;
    assign bus.out_vector = r_out;

    // Weight data lags its address by one cycle, so step k multiplies the
    // element addressed on step k-1.
    always_comb begin
        w_xsel = '0;
        if (r_k != '0) begin
            w_xsel = c_x_w'(r_k - c_k_w'(1));
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_in_fire)            w_state_next = ST_MAC;
            ST_MAC:  if (w_k_last && w_o_last) w_state_next = ST_DONE;
            ST_DONE: if (w_out_fire)           w_state_next = ST_IDLE;
            default:                           w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.w_rd_addr = '0;
        bus.b_rd_addr = '0;
        w_clr         = 1'b0;
        w_en          = 1'b0;
        w_last        = 1'b0;
        case (r_state)
            // r_alive keeps in_ready low while reset is asserted.
            ST_IDLE: bus.in_ready = r_alive;
            ST_MAC: begin
                bus.b_rd_addr = r_o;
                if (!w_k_last) begin
                    bus.w_rd_addr = r_waddr;
                end
                w_clr  = (r_k == '0);
                w_en   = (r_k != '0) && !w_k_last;
                w_last = w_k_last;
            end
            ST_DONE: bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------ counters and storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // r_waddr runs continuously across neuron boundaries, which yields
    // o*IN_SIZE+k without a multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= '0;
            r_o     <= '0;
            r_waddr <= '0;
            r_x     <= '0;
            r_out   <= '0;
        end else if (w_in_fire) begin
            r_x     <= bus.in_vector;
            r_k     <= '0;
            r_o     <= '0;
            r_waddr <= '0;
        end else if (r_state == ST_MAC) begin
            if (w_result_valid) begin
                r_out[r_o] <= w_result;
            end
            if (w_k_last) begin
                r_k <= '0;
                r_o <= r_o + c_o_w'(1);
            end else begin
                r_k     <= r_k + c_k_w'(1);
                r_waddr <= r_waddr + c_wa_w'(1);
            end
        end
    end

    dense_mac #(
        .IN_SIZE    (IN_SIZE),
        .IN_W       (IN_W),
        .W_W        (W_W),
        .B_W        (B_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .RELU       (RELU)
    ) u_mac (
        .clk          (clk),
        .rst          (rst),
        .clr          (w_clr),
        .en           (w_en),
        .last         (w_last),
        .x            (r_x[w_xsel]),
        .w            (bus.w_rd_data),
        .b            (bus.b_rd_data),
        .result       (w_result),
        .result_valid (w_result_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dense_layer_seq
//  Description : Directed self-checking bench. Three lock-stepped layers
//                (IN_SIZE=4, OUT_SIZE=2) share stimulus:
//                  a: RELU=1, OUT_W=24        b: RELU=0, OUT_W=24
//                  c: RELU=0, OUT_W=8, FRAC_SHIFT=2
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dense_layer_seq;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [3:0][7:0] in_vec = '0;

    int checks = 0;
    int errors = 0;

    logic signed [7:0]  wmem_ab [8];
    logic signed [15:0] bmem_ab [2];
    logic signed [7:0]  wmem_c  [8];
    logic signed [15:0] bmem_c  [2];

    always #5 clk = ~clk;

    dense_layer_seq_if #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(8), .W_W(8), .B_W(16), .OUT_W(24)) ifa ();
    dense_layer_seq_if #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(8), .W_W(8), .B_W(16), .OUT_W(24)) ifb ();
    dense_layer_seq_if #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(8), .W_W(8), .B_W(16), .OUT_W(8))  ifc ();

    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(8), .W_W(8), .B_W(16), .OUT_W(24),
                      .FRAC_SHIFT(0), .RELU(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(8), .W_W(8), .B_W(16), .OUT_W(24),
                      .FRAC_SHIFT(0), .RELU(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(8), .W_W(8), .B_W(16), .OUT_W(8),
                      .FRAC_SHIFT(2), .RELU(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    assign ifa.in_valid  = in_valid;
    assign ifa.in_vector = in_vec;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_vector = in_vec;
    assign ifb.out_ready = out_ready;
    assign ifc.in_valid  = in_valid;
    assign ifc.in_vector = in_vec;
    assign ifc.out_ready = out_ready;

    // Synchronous-read weight and bias memories.
    always @(posedge clk) begin
        ifa.w_rd_data <= wmem_ab[ifa.w_rd_addr];
        ifa.b_rd_data <= bmem_ab[ifa.b_rd_addr];
        ifb.w_rd_data <= wmem_ab[ifb.w_rd_addr];
        ifb.b_rd_data <= bmem_ab[ifb.b_rd_addr];
        ifc.w_rd_data <= wmem_c[ifc.w_rd_addr];
        ifc.b_rd_data <= bmem_c[ifc.b_rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][7:0] mkvec(input int e0, input int e1,
                                              input int e2, input int e3);
        logic [3:0][7:0] v;
        v[0] = e0[7:0];
        v[1] = e1[7:0];
        v[2] = e2[7:0];
        v[3] = e3[7:0];
        return v;
    endfunction

    task automatic check_ab(input string tag, input int a0, input int a1,
                            input int b0, input int b1);
        check({tag, " a[0]"}, 32'($signed(ifa.out_vector[0])), a0);
        check({tag, " a[1]"}, 32'($signed(ifa.out_vector[1])), a1);
        check({tag, " b[0]"}, 32'($signed(ifb.out_vector[0])), b0);
        check({tag, " b[1]"}, 32'($signed(ifb.out_vector[1])), b1);
    endtask

    task automatic check_c(input string tag, input int c0, input int c1);
        check({tag, " c[0]"}, 32'($signed(ifc.out_vector[0])), c0);
        check({tag, " c[1]"}, 32'($signed(ifc.out_vector[1])), c1);
    endtask

    // Handshake a vector in, then wait (bounded) for out_valid and check
    // the latency counted from the capture edge.
    task automatic run_vector(input string tag, input logic [3:0][7:0] v);
        int cyc;
        cyc = 0;
        while (!ifa.in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " in_ready"}, 32'(ifa.in_ready), 1);
        in_vec   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!ifa.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, 11);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " in_ready after accept"}, 32'(ifa.in_ready), 1);
        check({tag, " out_valid after accept"}, 32'(ifa.out_valid), 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 8; i++) begin
            wmem_ab[i] = (i < 4) ? 8'sd1 : ((i == 4) ? -8'sd1 : 8'sd0);
            wmem_c[i]  = (i < 4) ? 8'sd127 : 8'sd1;
        end
        bmem_ab[0] = 16'sd5;
        bmem_ab[1] = 16'sd0;
        bmem_c[0]  = 16'sd0;
        bmem_c[1]  = 16'sd0;

        // ---- reset values
        repeat (3) tick();
        check("reset in_ready", 32'(ifa.in_ready), 0);
        check("reset out_valid", 32'(ifa.out_valid), 0);
        check("reset w_rd_addr", 32'(ifa.w_rd_addr), 0);
        check_ab("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check("post-reset in_ready", 32'(ifa.in_ready), 1);

        // ---- first vector: cycle-accurate address and valid timing
        in_vec   = mkvec(1, 2, 3, 4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check("busy out_valid", 32'(ifa.out_valid), 0);
            check("busy in_ready", 32'(ifa.in_ready), 0);
            if (c != 5 && c != 10) begin
                check("w_rd_addr seq", 32'(ifa.w_rd_addr), (c < 5) ? c - 1 : c - 2);
            end
            check("b_rd_addr seq", 32'(ifa.b_rd_addr), (c <= 5) ? 0 : 1);
            tick();
        end
        check("cycle 11 out_valid", 32'(ifa.out_valid), 1);
        check_ab("vec1", 15, 0, 15, -1);

        // ---- back-pressure with in_valid pulsing
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_vec   = mkvec(c, -c, 7, 9);
            tick();
            check("bp out_valid", 32'(ifa.out_valid), 1);
            check("bp in_ready", 32'(ifa.in_ready), 0);
            check("bp w_rd_addr", 32'(ifa.w_rd_addr), 0);
            check_ab("bp", 15, 0, 15, -1);
        end
        in_valid = 1'b0;
        accept("bp");

        // ---- old results persist into the next run, then reset aborts it
        in_vec   = mkvec(1, 1, 1, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check_ab("no clear", 15, 0, 15, -1);
        tick();
        rst = 1'b1;
        #1;
        check("abort out_valid", 32'(ifa.out_valid), 0);
        check("abort in_ready", 32'(ifa.in_ready), 0);
        check("abort w_rd_addr", 32'(ifa.w_rd_addr), 0);
        check("abort b_rd_addr", 32'(ifa.b_rd_addr), 0);
        check_ab("abort", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        check("abort release in_ready", 32'(ifa.in_ready), 1);
        run_vector("after abort", mkvec(2, 1, 0, -1));
        check_ab("after abort", 7, 0, 7, -2);
        accept("after abort");

        // ---- back-to-back vectors, out_ready tied high
        out_ready = 1'b1;
        in_vec    = mkvec(3, 0, 0, 0);
        in_valid  = 1'b1;
        tick();
        in_vec = mkvec(0, 0, 0, -2);
        cyc = 1;
        while (!ifa.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b first latency", cyc, 11);
        check_ab("b2b first", 8, 0, 8, -3);
        tick();
        check("b2b in_ready", 32'(ifa.in_ready), 1);
        check("b2b out_valid low", 32'(ifa.out_valid), 0);
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!ifa.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b second latency", cyc, 11);
        check_ab("b2b second", 3, 0, 3, 0);
        tick();
        check("b2b final in_ready", 32'(ifa.in_ready), 1);
        out_ready = 1'b0;

        // ---- saturation and shift on the 8-bit, FRAC_SHIFT=2 layer
        run_vector("sat pos", mkvec(127, 127, 127, 127));
        check_c("sat pos", 127, 127);
        accept("sat pos");
        run_vector("sat neg", mkvec(-128, -128, -128, -128));
        check_c("sat neg", -128, -128);
        accept("sat neg");
        run_vector("shift pos", mkvec(4, 4, 4, 4));
        check_c("shift pos", 127, 4);
        accept("shift pos");
        run_vector("shift neg", mkvec(-4, -4, -4, -4));
        check_c("shift neg", -128, -4);
        accept("shift neg");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
